gray_seq_counter: RTL and testbench

- Parametrised successor to the 2-bit x_in-stepped sequence FSM.
- Generalises it to a WIDTH-bit reflected-Gray-code sequencer with direction control, synchronous clear, parallel load, terminal-count and wrap flags.
- With WIDTH=2, dir=up and no load/clear, it reproduces the 00→01→11→10→00 sequence, advancing only while x_in=1.
- Used wherever a glitch-free multi-bit position code crosses into other logic: pointers, phase sequencers.

---
 rtl/gray_seq_pkg.sv | 22 ++
 rtl/gray_seq_counter_gray_to_bin.sv | 20 ++
 rtl/gray_seq_counter.sv | 94 +++++++++
 tb/tb_gray_seq_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray-code sequencer.
// Both helpers work at the maximum legal width (16). Callers zero-extend narrower values and slice the result.
package gray_seq_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int   MAX_W    = 16;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_seq_counter_gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray_to_bin #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        logic acc;
        acc   = 1'b0;
        o_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ i_gray[i];
            o_bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_seq_counter.sv
// WIDTH-bit reflected-Gray sequencer with direction, clear, load, terminal-count and wrap flags.
// Optional build macro GRAY_SEQ_SATURATE_EN: steps at the end code are suppressed, and a sat pulse is raised for each suppressed step.
module gray_seq_counter
    import gray_seq_pkg::*;
#(
    parameter int          WIDTH      = 2,
    parameter int unsigned RESET_CODE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_code,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state,
    output logic [WIDTH-1:0] bin_count,
    output logic             tc,
    output logic             wrap
`ifdef GRAY_SEQ_SATURATE_EN
    ,
    output logic             sat
`endif
);

    localparam logic [WIDTH-1:0] L_RESET_CODE = WIDTH'(RESET_CODE);

    logic [WIDTH-1:0] r_state;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_gray_step;
    logic             w_step_req;
    logic             w_advance;
    logic             w_wrap_d;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .i_gray (r_state),
        .o_bin  (w_bin)
    );

    assign w_bin_step  = (dir == DIR_UP) ? w_bin + 1'b1 : w_bin - 1'b1;
    assign w_gray_step = WIDTH'(bin2gray(MAX_W'(w_bin_step)));

    assign tc         = (dir == DIR_UP) ? (w_bin == '1) : (w_bin == '0);
    assign w_step_req = x_in & ~clear & ~load;

`ifdef GRAY_SEQ_SATURATE_EN
    logic r_sat;

    assign w_advance = w_step_req & ~tc;
    assign w_wrap_d  = 1'b0;
    assign sat       = r_sat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= w_step_req & tc;
        end
    end
`else
    assign w_advance = w_step_req;
    assign w_wrap_d  = w_step_req & tc;
`endif

    // Priority: clear over load over step.
    always_comb begin
        next_state = r_state;
        if (clear) begin
            next_state = L_RESET_CODE;
        end else if (load) begin
            next_state = load_code;
        end else if (w_advance) begin
            next_state = w_gray_step;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= L_RESET_CODE;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= next_state;
            r_wrap  <= w_wrap_d;
        end
    end

    assign state     = r_state;
    assign bin_count = w_bin;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_seq_counter.sv
// Directed bench for gray_seq_counter using a WIDTH=2 instance and a WIDTH=4 instance.
// The wrap scenarios run in the default build. The saturation scenario runs when GRAY_SEQ_SATURATE_EN is defined.
module tb_gray_seq_counter;

    logic clock = 1'b0;
    logic reset;

    logic       x2, dir2, clr2, ld2;
    logic [1:0] lc2, st2, ns2, bc2;
    logic       tc2, wr2;

    logic       x4, dir4, clr4, ld4;
    logic [3:0] lc4, st4, ns4, bc4;
    logic       tc4, wr4;

`ifdef GRAY_SEQ_SATURATE_EN
    logic sat2, sat4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    gray_seq_counter #(.WIDTH(2), .RESET_CODE(0)) dut2 (
        .clock(clock), .reset(reset), .x_in(x2), .dir(dir2), .clear(clr2), .load(ld2),
        .load_code(lc2), .state(st2), .next_state(ns2), .bin_count(bc2), .tc(tc2), .wrap(wr2)
`ifdef GRAY_SEQ_SATURATE_EN
        , .sat(sat2)
`endif
    );

    gray_seq_counter #(.WIDTH(4), .RESET_CODE(0)) dut4 (
        .clock(clock), .reset(reset), .x_in(x4), .dir(dir4), .clear(clr4), .load(ld4),
        .load_code(lc4), .state(st4), .next_state(ns4), .bin_count(bc4), .tc(tc4), .wrap(wr4)
`ifdef GRAY_SEQ_SATURATE_EN
        , .sat(sat4)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] exp_s [5];
        logic [1:0] exp_b [5];
        logic       exp_w [5];
        logic       exp_t [5];
        logic       xpat  [4];
        logic [1:0] xns   [4];

        reset = 1'b1;
        x2 = 0; dir2 = 0; clr2 = 0; ld2 = 0; lc2 = '0;
        x4 = 0; dir4 = 0; clr4 = 0; ld4 = 0; lc4 = '0;
        #2;
        chk("async_reset_state2", 16'(st2), 16'h0);
        chk("async_reset_wrap2", 16'(wr2), 16'h0);
        tick();
        chk("reset_state4", 16'(st4), 16'h0);
        chk("reset_bin2", 16'(bc2), 16'h0);
        chk("reset_tc2_up", 16'(tc2), 16'h0);
        reset = 1'b0;

`ifndef GRAY_SEQ_SATURATE_EN
        // WIDTH=2, up, continuous stepping
        exp_s = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        x2 = 1'b1;
        #1;
        chk("w2_next_from_reset", 16'(ns2), 16'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("w2_up_state[%0d]", i), 16'(st2), 16'(exp_s[i]));
            chk($sformatf("w2_up_bin[%0d]", i), 16'(bc2), 16'(exp_b[i]));
            chk($sformatf("w2_up_wrap[%0d]", i), 16'(wr2), 16'(exp_w[i]));
            chk($sformatf("w2_up_tc[%0d]", i), 16'(tc2), 16'(exp_t[i]));
        end

        // Clear back to 00, then x_in pattern 1,0,0,1
        x2 = 1'b0; clr2 = 1'b1;
        tick();
        chk("w2_clear_state", 16'(st2), 16'h0);
        clr2 = 1'b0;
        xpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        xns  = '{2'b01, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            x2 = xpat[i];
            #1;
            chk($sformatf("w2_xin_next[%0d]", i), 16'(ns2), 16'(xns[i]));
            tick();
            chk($sformatf("w2_xin_state[%0d]", i), 16'(st2), 16'(xns[i]));
        end
        x2 = 1'b0;

        // WIDTH=4, down from 0000
        dir4 = 1'b1; x4 = 1'b1;
        #1;
        chk("w4_down_tc_at_zero", 16'(tc4), 16'h1);
        chk("w4_down_next", 16'(ns4), 16'h8);
        tick();
        chk("w4_down_state1", 16'(st4), 16'h8);
        chk("w4_down_bin1", 16'(bc4), 16'hF);
        chk("w4_down_wrap1", 16'(wr4), 16'h1);
        chk("w4_down_tc1", 16'(tc4), 16'h0);
        tick();
        chk("w4_down_state2", 16'(st4), 16'h9);
        chk("w4_down_wrap2", 16'(wr4), 16'h0);

        // Clear beats load and step, then load beats step
        dir4 = 1'b0; clr4 = 1'b1; ld4 = 1'b1; lc4 = 4'b0110;
        tick();
        chk("w4_clear_over_load", 16'(st4), 16'h0);
        chk("w4_clear_wrap", 16'(wr4), 16'h0);
        clr4 = 1'b0;
        tick();
        chk("w4_load_state", 16'(st4), 16'h6);
        chk("w4_load_bin", 16'(bc4), 16'h4);
        ld4 = 1'b0;
        tick();
        chk("w4_step_after_load", 16'(st4), 16'h7);

        // Load 1000 (binary 15), step up across the end, then reset mid-cycle
        ld4 = 1'b1; lc4 = 4'b1000; x4 = 1'b0;
        tick();
        ld4 = 1'b0; x4 = 1'b1;
        #1;
        chk("w4_up_tc_at_15", 16'(tc4), 16'h1);
        tick();
        chk("w4_up_wrap_state", 16'(st4), 16'h0);
        chk("w4_up_wrap_pulse", 16'(wr4), 16'h1);
        ld4 = 1'b1; lc4 = 4'b1100;
        tick();
        chk("w4_load_before_reset", 16'(st4), 16'hC);
        ld4 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("w4_async_reset_state", 16'(st4), 16'h0);
        chk("w4_async_reset_wrap", 16'(wr4), 16'h0);
        #2;
        reset = 1'b0;
        tick();
        chk("w4_restart_state", 16'(st4), 16'h1);
        chk("w4_restart_wrap", 16'(wr4), 16'h0);
        x4 = 1'b0;
`else
        // WIDTH=2 saturating: 01, 11, 10, then hold at 10 with sat pulses
        exp_s = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        x2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_state[%0d]", i), 16'(st2), 16'(exp_s[i]));
            chk($sformatf("sat_pulse[%0d]", i), 16'(sat2), 16'(exp_w[i]));
            chk($sformatf("sat_wrap[%0d]", i), 16'(wr2), 16'h0);
        end
        chk("sat_next_holds", 16'(ns2), 16'h2);
        x2 = 1'b0;
        tick();
        chk("sat_release", 16'(sat2), 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
